dram_cache_rob: RTL and testbench

- In-order reorder buffer for read requests to the DRAM cache.
- Sits directly downstream of the tag comparator. The read-hit data path and the miss-fill data path both write returned lines into slots here.
- Slots are allocated in request-arrival order by the request FIFO stage.
- Lines are released to the host AXI R channel strictly in allocation order, one beat per request, with the original ID.

---
 rtl/dram_cache_rob.sv | 169 ++++++++++++++++
 tb/tb_dram_cache_rob.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_cache_rob.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module      : dram_cache_rob                                              |
// | Description : In-order reorder buffer for DRAM-cache read requests.       |
// |               Slots are allocated in request-arrival order, filled in any |
// |               order by the hit/miss-fill data paths, and released to the  |
// |               host AXI R channel strictly in allocation order, one beat   |
// |               per request, carrying the original ID.                      |
// | Revision    : 1.0 - initial release                                       |
// +---------------------------------------------------------------------------+
// | Ports                                                                     |
// |   clk, rst        : single rising-edge clock, synchronous active-high rst |
// |   alloc_*         : slot allocation handshake from the request FIFO       |
// |   fill_*          : line data (and error) written into an allocated slot  |
// |   rid_o .. rready_i : AXI R channel toward the host                       |
// |   count_o         : number of allocated slots                             |
// |   err_o           : sticky illegal-fill flag                              |
// +---------------------------------------------------------------------------+
// | Optional feature macro: DRAM_CACHE_ROB_ERR_CHECK_EN                       |
// |   defined   : err_o latches any fill to an unallocated/already-filled     |
// |               slot; simulation assertions on overflow and X fill index.   |
// |   undefined : err_o tied 0, illegal fills silently dropped.               |
// +---------------------------------------------------------------------------+
module dram_cache_rob #(
    parameter  int ID_WIDTH   = 4,
    parameter  int DATA_WIDTH = 512,
    parameter  int DEPTH      = 8,
    localparam int IDX_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    // allocation
    input  logic                  alloc_valid_i,
    input  logic [ID_WIDTH-1:0]   alloc_id_i,
    output logic                  alloc_ready_o,
    output logic [IDX_W-1:0]      alloc_idx_o,
    // fill
    input  logic                  fill_valid_i,
    input  logic [IDX_W-1:0]      fill_idx_i,
    input  logic [DATA_WIDTH-1:0] fill_data_i,
    input  logic                  fill_err_i,
    // AXI R channel
    output logic [ID_WIDTH-1:0]   rid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic [1:0]            rresp_o,
    output logic                  rlast_o,
    output logic                  rvalid_o,
    input  logic                  rready_i,
    // status
    output logic [IDX_W:0]        count_o,
    output logic                  err_o
);

    localparam logic [IDX_W:0] c_PTR_ONE  = {{IDX_W{1'b0}}, 1'b1};
    localparam logic [1:0]     c_RESP_OK  = 2'b00;
    localparam logic [1:0]     c_RESP_ERR = 2'b10;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [IDX_W:0]        r_head;
    logic [IDX_W:0]        r_tail;
    logic [DEPTH-1:0]      r_alloc;
    logic [DEPTH-1:0]      r_filled;

    // Payload storage; validity is tracked solely by r_alloc/r_filled,
    // so these arrays are intentionally not reset.
    logic [ID_WIDTH-1:0]   r_id_mem   [DEPTH];
    logic [DATA_WIDTH-1:0] r_data_mem [DEPTH];
    logic                  r_err_mem  [DEPTH];

    logic [IDX_W-1:0]      w_head_idx;
    logic [IDX_W-1:0]      w_tail_idx;
    logic                  w_full;
    logic                  w_head_valid;
    logic                  w_alloc;
    logic                  w_fill_ok;
    logic                  w_release;

    assign w_head_idx   = r_head[IDX_W-1:0];
    assign w_tail_idx   = r_tail[IDX_W-1:0];
    assign w_full       = (w_head_idx == w_tail_idx) && (r_head[IDX_W] != r_tail[IDX_W]);
    assign w_head_valid = r_alloc[w_head_idx] && r_filled[w_head_idx];

    // Ready is derived from registered state only: a release in this cycle
    // does not free a slot for an allocation in the same cycle.
    assign w_alloc   = alloc_valid_i && !w_full;
    assign w_fill_ok = fill_valid_i && r_alloc[fill_idx_i] && !r_filled[fill_idx_i];
    assign w_release = w_head_valid && rready_i;

    // The three updates below never collide on one slot: a fill needs an
    // allocated-but-unfilled slot, release needs a filled head, and the
    // tail slot is unallocated whenever an allocation is granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head   <= '0;
            r_tail   <= '0;
            r_alloc  <= '0;
            r_filled <= '0;
        end else begin
            if (w_release) begin
                r_alloc[w_head_idx]  <= 1'b0;
                r_filled[w_head_idx] <= 1'b0;
                r_head               <= r_head + c_PTR_ONE;
            end
            if (w_alloc) begin
                r_alloc[w_tail_idx]  <= 1'b1;
                r_filled[w_tail_idx] <= 1'b0;
                r_tail               <= r_tail + c_PTR_ONE;
            end
            if (w_fill_ok) begin
                r_filled[fill_idx_i] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_id_mem[w_tail_idx] <= alloc_id_i;
        end
        if (w_fill_ok) begin
            r_data_mem[fill_idx_i] <= fill_data_i;
            r_err_mem[fill_idx_i]  <= fill_err_i;
        end
    end

    assign alloc_ready_o = !w_full;
    assign alloc_idx_o   = w_tail_idx;
    assign count_o       = r_tail - r_head;

    // Beat fields are masked to zero when no beat is offered so that the
    // unreset payload RAM never shows through on the R channel.
    assign rvalid_o = w_head_valid;
    assign rlast_o  = w_head_valid;
    assign rid_o    = w_head_valid ? r_id_mem[w_head_idx]   : '0;
    assign rdata_o  = w_head_valid ? r_data_mem[w_head_idx] : '0;
    assign rresp_o  = !w_head_valid          ? c_RESP_OK  :
                      r_err_mem[w_head_idx]  ? c_RESP_ERR : c_RESP_OK;

`ifdef DRAM_CACHE_ROB_ERR_CHECK_EN
    logic w_fill_bad;
    logic r_err;

    assign w_fill_bad = fill_valid_i && !w_fill_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_fill_bad) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(alloc_valid_i && w_full))
                else $error("dram_cache_rob: allocation requested while full");
            if (fill_valid_i) begin
                assert (!$isunknown(fill_idx_i))
                    else $error("dram_cache_rob: fill index unknown");
            end
        end
    end
`else
    assign err_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dram_cache_rob.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module      : tb_dram_cache_rob                                           |
// | Description : Directed self-checking bench for dram_cache_rob             |
// |               (DEPTH=8, ID_WIDTH=4, DATA_WIDTH=512).                      |
// | Revision    : 1.0 - initial release                                       |
// +---------------------------------------------------------------------------+
module tb_dram_cache_rob;

    localparam int c_IDW   = 4;
    localparam int c_DW    = 512;
    localparam int c_DEPTH = 8;
    localparam int c_IW    = 3;

`ifdef DRAM_CACHE_ROB_ERR_CHECK_EN
    localparam logic c_ERR_EN = 1'b1;
`else
    localparam logic c_ERR_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              alloc_valid_i;
    logic [c_IDW-1:0]  alloc_id_i;
    logic              alloc_ready_o;
    logic [c_IW-1:0]   alloc_idx_o;
    logic              fill_valid_i;
    logic [c_IW-1:0]   fill_idx_i;
    logic [c_DW-1:0]   fill_data_i;
    logic              fill_err_i;
    logic [c_IDW-1:0]  rid_o;
    logic [c_DW-1:0]   rdata_o;
    logic [1:0]        rresp_o;
    logic              rlast_o;
    logic              rvalid_o;
    logic              rready_i;
    logic [c_IW:0]     count_o;
    logic              err_o;

    int checks = 0;
    int errors = 0;

    dram_cache_rob #(
        .ID_WIDTH   (c_IDW),
        .DATA_WIDTH (c_DW),
        .DEPTH      (c_DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .alloc_valid_i (alloc_valid_i),
        .alloc_id_i    (alloc_id_i),
        .alloc_ready_o (alloc_ready_o),
        .alloc_idx_o   (alloc_idx_o),
        .fill_valid_i  (fill_valid_i),
        .fill_idx_i    (fill_idx_i),
        .fill_data_i   (fill_data_i),
        .fill_err_i    (fill_err_i),
        .rid_o         (rid_o),
        .rdata_o       (rdata_o),
        .rresp_o       (rresp_o),
        .rlast_o       (rlast_o),
        .rvalid_o      (rvalid_o),
        .rready_i      (rready_i),
        .count_o       (count_o),
        .err_o         (err_o)
    );

    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkd(input string tag, input logic [c_DW-1:0] obs, input logic [c_DW-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [c_DW-1:0] mk(input int n);
        logic [31:0] w;
        w = 32'hD000_0000 + n;
        return {16{w}};
    endfunction

    task automatic fill(input int idx, input int n, input logic err);
        fill_valid_i = 1'b1;
        fill_idx_i   = c_IW'(idx);
        fill_data_i  = mk(n);
        fill_err_i   = err;
    endtask

    initial begin
        rst           = 1'b1;
        alloc_valid_i = 1'b0;
        alloc_id_i    = '0;
        fill_valid_i  = 1'b0;
        fill_idx_i    = '0;
        fill_data_i   = '0;
        fill_err_i    = 1'b0;
        rready_i      = 1'b0;
        tick();
        tick();

        // ---- reset values
        chk("rst_ready", 64'(alloc_ready_o), 64'd1);
        chk("rst_idx",   64'(alloc_idx_o),   64'd0);
        chk("rst_rvalid",64'(rvalid_o),      64'd0);
        chk("rst_rlast", 64'(rlast_o),       64'd0);
        chk("rst_rresp", 64'(rresp_o),       64'd0);
        chk("rst_rid",   64'(rid_o),         64'd0);
        chk("rst_count", 64'(count_o),       64'd0);
        chk("rst_err",   64'(err_o),         64'd0);
        chkd("rst_rdata", rdata_o, '0);
        rst = 1'b0;

        // ---- in-order fills, back-to-back release
        alloc_valid_i = 1'b1;
        alloc_id_i = 4'd3; chk("t1_idx0", 64'(alloc_idx_o), 64'd0); tick();
        alloc_id_i = 4'd5; chk("t1_idx1", 64'(alloc_idx_o), 64'd1); tick();
        alloc_id_i = 4'd7; chk("t1_idx2", 64'(alloc_idx_o), 64'd2); tick();
        alloc_valid_i = 1'b0;
        chk("t1_count3", 64'(count_o), 64'd3);
        chk("t1_nov",    64'(rvalid_o), 64'd0);
        rready_i = 1'b1;
        fill(0, 0, 1'b0); tick();
        chk("t1_v0",     64'(rvalid_o), 64'd1);
        chk("t1_rid0",   64'(rid_o),    64'd3);
        chk("t1_resp0",  64'(rresp_o),  64'd0);
        chk("t1_last0",  64'(rlast_o),  64'd1);
        chk("t1_cnt_a",  64'(count_o),  64'd3);
        chkd("t1_data0", rdata_o, mk(0));
        fill(1, 1, 1'b0); tick();
        chk("t1_rid1",   64'(rid_o),    64'd5);
        chk("t1_cnt_b",  64'(count_o),  64'd2);
        chkd("t1_data1", rdata_o, mk(1));
        fill(2, 2, 1'b0); tick();
        chk("t1_rid2",   64'(rid_o),    64'd7);
        chk("t1_cnt_c",  64'(count_o),  64'd1);
        fill_valid_i = 1'b0; tick();
        chk("t1_empty",  64'(rvalid_o), 64'd0);
        chk("t1_cnt_d",  64'(count_o),  64'd0);
        rready_i = 1'b0;

        // ---- out-of-order fills (slots 3,4,5; filled 5,3,4)
        alloc_valid_i = 1'b1;
        alloc_id_i = 4'd1; chk("t2_idx3", 64'(alloc_idx_o), 64'd3); tick();
        alloc_id_i = 4'd2; chk("t2_idx4", 64'(alloc_idx_o), 64'd4); tick();
        alloc_id_i = 4'd3; chk("t2_idx5", 64'(alloc_idx_o), 64'd5); tick();
        alloc_valid_i = 1'b0;
        rready_i = 1'b1;
        fill(5, 15, 1'b0); tick();
        chk("t2_nov",    64'(rvalid_o), 64'd0);
        chk("t2_cnt",    64'(count_o),  64'd3);
        fill(3, 13, 1'b0); tick();
        chk("t2_v",      64'(rvalid_o), 64'd1);
        chk("t2_rid_a",  64'(rid_o),    64'd1);
        chkd("t2_dat_a", rdata_o, mk(13));
        fill(4, 14, 1'b0); tick();
        chk("t2_rid_b",  64'(rid_o),    64'd2);
        chkd("t2_dat_b", rdata_o, mk(14));
        fill_valid_i = 1'b0; tick();
        chk("t2_rid_c",  64'(rid_o),    64'd3);
        chkd("t2_dat_c", rdata_o, mk(15));
        tick();
        chk("t2_empty",  64'(rvalid_o), 64'd0);
        chk("t2_cnt0",   64'(count_o),  64'd0);
        rready_i = 1'b0;

        // ---- full, release with blocked concurrent alloc
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t3_cnt0",   64'(count_o),     64'd0);
        chk("t3_idx0",   64'(alloc_idx_o), 64'd0);
        alloc_valid_i = 1'b1;
        for (int i = 0; i < c_DEPTH; i++) begin
            alloc_id_i = c_IDW'(i);
            tick();
        end
        alloc_valid_i = 1'b0;
        chk("t3_full_rdy", 64'(alloc_ready_o), 64'd0);
        chk("t3_full_cnt", 64'(count_o),       64'd8);
        fill(0, 20, 1'b0); tick();
        fill_valid_i = 1'b0;
        chk("t3_v",        64'(rvalid_o), 64'd1);
        chk("t3_rid",      64'(rid_o),    64'd0);
        rready_i = 1'b1; alloc_valid_i = 1'b1; alloc_id_i = 4'd9;
        chk("t3_blk_rdy",  64'(alloc_ready_o), 64'd0);
        tick();
        chk("t3_cnt7",     64'(count_o),       64'd7);
        chk("t3_rdy1",     64'(alloc_ready_o), 64'd1);
        chk("t3_wrapidx",  64'(alloc_idx_o),   64'd0);
        rready_i = 1'b0; tick();
        alloc_valid_i = 1'b0;
        chk("t3_cnt8",     64'(count_o),       64'd8);
        chk("t3_rdy0",     64'(alloc_ready_o), 64'd0);
        chk("t3_nov",      64'(rvalid_o),      64'd0);

        // ---- back-pressure: head held stable
        fill(1, 21, 1'b0); tick();
        fill_valid_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("t4_hold_v",   64'(rvalid_o), 64'd1);
            chk("t4_hold_rid", 64'(rid_o),    64'd1);
            chkd("t4_hold_dat", rdata_o, mk(21));
            tick();
        end
        rready_i = 1'b1;
        chk("t4_v_rel",    64'(rvalid_o), 64'd1);
        tick();
        rready_i = 1'b0;
        chk("t4_after",    64'(rvalid_o), 64'd0);
        chk("t4_cnt7",     64'(count_o),  64'd7);

        // ---- error response and illegal fills
        fill(2, 22, 1'b1); tick();
        chk("t5_v",        64'(rvalid_o), 64'd1);
        chk("t5_rid",      64'(rid_o),    64'd2);
        chk("t5_slverr",   64'(rresp_o),  64'd2);
        chk("t5_err_clr",  64'(err_o),    64'd0);
        fill(2, 99, 1'b0); tick();
        fill_valid_i = 1'b0;
        chk("t5_refill_resp", 64'(rresp_o), 64'd2);
        chkd("t5_refill_dat",  rdata_o, mk(22));
        chk("t5_refill_cnt",  64'(count_o), 64'd7);
        chk("t5_err_set",     64'(err_o),   64'(c_ERR_EN));
        rready_i = 1'b1; tick(); rready_i = 1'b0;
        chk("t5_rel_nov",  64'(rvalid_o), 64'd0);
        chk("t5_rel_cnt",  64'(count_o),  64'd6);
        fill(2, 98, 1'b0); tick();
        fill_valid_i = 1'b0;
        chk("t5_unal_nov", 64'(rvalid_o), 64'd0);
        chk("t5_unal_cnt", 64'(count_o),  64'd6);
        tick();
        chk("t5_err_stk",  64'(err_o),    64'(c_ERR_EN));

        // ---- reset with 4 outstanding, 2 filled
        rst = 1'b1; tick(); rst = 1'b0;
        alloc_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            alloc_id_i = c_IDW'(10 + i);
            tick();
        end
        alloc_valid_i = 1'b0;
        fill(0, 30, 1'b0); tick();
        fill(2, 32, 1'b0); tick();
        fill_valid_i = 1'b0;
        chk("t6_cnt4",     64'(count_o),  64'd4);
        chk("t6_v",        64'(rvalid_o), 64'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t6_rst_v",    64'(rvalid_o),      64'd0);
        chk("t6_rst_cnt",  64'(count_o),       64'd0);
        chk("t6_rst_idx",  64'(alloc_idx_o),   64'd0);
        chk("t6_rst_rdy",  64'(alloc_ready_o), 64'd1);
        chk("t6_rst_err",  64'(err_o),         64'd0);
        rready_i = 1'b1;
        fill(0, 31, 1'b0); tick();
        fill_valid_i = 1'b0;
        chk("t6_stale_v",  64'(rvalid_o), 64'd0);
        tick();
        chk("t6_stale_v2", 64'(rvalid_o), 64'd0);
        alloc_valid_i = 1'b1; alloc_id_i = 4'd6;
        chk("t6_new_idx",  64'(alloc_idx_o), 64'd0);
        tick();
        alloc_valid_i = 1'b0;
        chk("t6_new_cnt",  64'(count_o),  64'd1);
        chk("t6_new_nov",  64'(rvalid_o), 64'd0);
        fill(0, 40, 1'b0); tick();
        fill_valid_i = 1'b0;
        chk("t6_new_v",    64'(rvalid_o), 64'd1);
        chk("t6_new_rid",  64'(rid_o),    64'd6);
        chkd("t6_new_dat", rdata_o, mk(40));
        tick();
        chk("t6_done_v",   64'(rvalid_o), 64'd0);
        chk("t6_done_cnt", 64'(count_o),  64'd0);
        rready_i = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
